// File: rtl/fp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// fp_pkg : shared single-precision constants, types and FSM states
// Rev 1.0
// ---------------------------------------------------------------
package fp_pkg;

   localparam int          FP_BIAS    = 127;
   localparam int          FP_EXP_W   = 8;
   localparam int          FP_MANT_W  = 23;
   localparam logic [7:0]  FP_EXP_INF = 8'hFF;

   // mant carries the implicit leading one, hence FP_MANT_W+1 bits
   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_MANT_W:0]   mant;
   } fp_unpacked_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_NORM = 2'd2
   } fdiv_state_e;

endpackage
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ---------------------------------------------------------------
// fp_unpack : split a single-precision word, add implicit one, flag zero
// Rev 1.0
// ---------------------------------------------------------------
module fp_unpack
   import fp_pkg::*;
(
   input  logic [31:0]  word_i,
   output fp_unpacked_t unp_o,
   output logic         zero_o
);

   always_comb begin
      unp_o.sign = word_i[31];
      unp_o.exp  = word_i[30:23];
      unp_o.mant = {1'b1, word_i[22:0]};
      zero_o     = (word_i[30:0] == 31'h0);
   end

endmodule
`default_nettype wire

// File: rtl/fdiv_seq.sv
`default_nettype none
// ---------------------------------------------------------------
// fdiv_seq : 25-iteration restoring single-precision divider, truncating
// Rev 1.0
// ---------------------------------------------------------------
module fdiv_seq
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        div_by_zero
);

   fp_unpacked_t w_ua, w_ub;
   logic         w_za, w_zb;

   fp_unpack u_unpack_a (.word_i(a), .unp_o(w_ua), .zero_o(w_za));
   fp_unpack u_unpack_b (.word_i(b), .unp_o(w_ub), .zero_o(w_zb));

   fdiv_state_e state_q, state_d;
   logic        sign_q, sign_d;
   logic [9:0]  pre_q, pre_d;
   logic [24:0] r_q, r_d;
   logic [23:0] d_q, d_d;
   logic [24:0] q_q, q_d;
   logic [4:0]  k_q, k_d;
   logic        za_q, za_d, zb_q, zb_d;
   logic [31:0] result_q, result_d;
   logic        dbz_q, dbz_d;
   logic        done_q, done_d;

   logic        w_ge;
   logic [24:0] w_sub;

   assign w_ge  = (r_q >= {1'b0, d_q});
   assign w_sub = r_q - {1'b0, d_q};

   // Only the low 8 bits of the pre-exponent feed the result (mod-256 wrap)
   logic unused_pre;
   assign unused_pre = &{1'b0, pre_q[9:8]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sign_q   <= 1'b0;
         pre_q    <= '0;
         r_q      <= '0;
         d_q      <= '0;
         q_q      <= '0;
         k_q      <= '0;
         za_q     <= 1'b0;
         zb_q     <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         pre_q    <= pre_d;
         r_q      <= r_d;
         d_q      <= d_d;
         q_q      <= q_d;
         k_q      <= k_d;
         za_q     <= za_d;
         zb_q     <= zb_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      pre_d    = pre_q;
      r_d      = r_q;
      d_d      = d_q;
      q_d      = q_q;
      k_d      = k_q;
      za_d     = za_q;
      zb_d     = zb_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sign_d  = w_ua.sign ^ w_ub.sign;
               pre_d   = {2'b00, w_ua.exp} - {2'b00, w_ub.exp} + 10'(FP_BIAS);
               r_d     = {1'b0, w_ua.mant};
               d_d     = w_ub.mant;
               q_d     = '0;
               k_d     = '0;
               za_d    = w_za;
               zb_d    = w_zb;
               state_d = ST_DIV;
            end
         end
         ST_DIV: begin
            // Partial remainder stays below 2*D, so bit 24 is dropped safely by the shift
            q_d = {q_q[23:0], w_ge};
            r_d = w_ge ? {w_sub[23:0], 1'b0} : {r_q[23:0], 1'b0};
            k_d = k_q + 5'd1;
            if (k_q == 5'd24) state_d = ST_NORM;
         end
         ST_NORM: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (zb_q) begin
               result_d = {sign_q, FP_EXP_INF, 23'h0};
               dbz_d    = 1'b1;
            end else if (za_q) begin
               result_d = {sign_q, 31'h0};
               dbz_d    = 1'b0;
            end else if (q_q[24]) begin
               result_d = {sign_q, pre_q[7:0], q_q[23:1]};
               dbz_d    = 1'b0;
            end else begin
               result_d = {sign_q, pre_q[7:0] - 8'd1, q_q[22:0]};
               dbz_d    = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
